// File: rtl/mp_adder_pkg.sv
// Shared definitions for the multi-player adder with access-code lock:
// FSM state encodings and default parameter values.
package mp_adder_pkg;

    typedef enum logic [2:0] {
        S_WAIT  = 3'd0,
        S_OPEN  = 3'd1,
        S_ALARM = 3'd2
    } state_t;

    localparam int          DEF_NPLAYERS = 2;
    localparam int          DEF_DW       = 4;
    localparam int          DEF_PWD_LEN  = 4;
    localparam logic [15:0] DEF_PWD      = 16'h3153;
    localparam int          DEF_MAX_FAIL = 3;

endpackage

// File: rtl/mp_adder_ctl_if.sv
// Bundles the player bus, the code-entry inputs and the status outputs.
interface mp_adder_ctl_if import mp_adder_pkg::*; #(
    parameter int NPLAYERS = DEF_NPLAYERS,
    parameter int DW       = DEF_DW
) ();

    logic [NPLAYERS*DW-1:0]           p_data;
    logic [NPLAYERS-1:0]              p_bpress;
    logic [3:0]                       acc_data;
    logic                             acc_bpress;
    logic [NPLAYERS*DW-1:0]           p_val;
    logic [DW+$clog2(NPLAYERS)-1:0]   sum;
    logic                             sum_valid;
    logic                             pass_g;
    logic                             pass_r;
    logic [2:0]                       acc_state;

    modport master (
        output p_data, p_bpress, acc_data, acc_bpress,
        input  p_val, sum, sum_valid, pass_g, pass_r, acc_state
    );

    modport slave (
        input  p_data, p_bpress, acc_data, acc_bpress,
        output p_val, sum, sum_valid, pass_g, pass_r, acc_state
    );

endinterface

// File: rtl/mp_adder_ctl_pwd_checker.sv
// Access-code entry tracker: digit index, per-attempt mismatch flag and
// failed-attempt counter; raises single-cycle grant/alarm pulses.
module pwd_checker import mp_adder_pkg::*; #(
    parameter int                   PWD_LEN  = DEF_PWD_LEN,
    parameter logic [PWD_LEN*4-1:0] PWD      = DEF_PWD,
    parameter int                   MAX_FAIL = DEF_MAX_FAIL
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enable_i,
    input  logic [3:0] digit_i,
    input  logic       press_i,
    output logic       grant_o,
    output logic       alarm_o
);

    localparam int IDXW = (PWD_LEN > 1) ? $clog2(PWD_LEN) : 1;
    localparam int FW   = $clog2(MAX_FAIL + 1);

    logic [IDXW-1:0] digitIdx_q, digitIdx_d;
    logic            mismatch_q, mismatch_d;
    logic [FW-1:0]   failCnt_q, failCnt_d;
    logic [3:0]      expDigit;
    logic            lastDigit;
    logic            attemptBad;
    logic [FW:0]     failNext;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            digitIdx_q <= '0;
            mismatch_q <= 1'b0;
            failCnt_q  <= '0;
        end else begin
            digitIdx_q <= digitIdx_d;
            mismatch_q <= mismatch_d;
            failCnt_q  <= failCnt_d;
        end
    end

    // The most-significant digit of PWD is the first one entered.
    always_comb begin
        expDigit   = 4'(PWD >> (4 * (PWD_LEN - 1 - int'(digitIdx_q))));
        lastDigit  = (int'(digitIdx_q) == PWD_LEN - 1);
        attemptBad = mismatch_q || (digit_i != expDigit);
        failNext   = {1'b0, failCnt_q} + (FW+1)'(1);
        digitIdx_d = digitIdx_q;
        mismatch_d = mismatch_q;
        failCnt_d  = failCnt_q;
        grant_o    = 1'b0;
        alarm_o    = 1'b0;
        if (enable_i && press_i) begin
            if (lastDigit) begin
                digitIdx_d = '0;
                mismatch_d = 1'b0;
                if (!attemptBad) begin
                    failCnt_d = '0;
                    grant_o   = 1'b1;
                end else begin
                    failCnt_d = failNext[FW-1:0];
                    alarm_o   = (failNext >= (FW+1)'(MAX_FAIL));
                end
            end else begin
                digitIdx_d = digitIdx_q + IDXW'(1);
                mismatch_d = attemptBad;
            end
        end
    end

endmodule

// File: rtl/mp_adder_ctl.sv
// Multi-player adder gated by an access code: players may load values
// only while unlocked; the registered sum follows one cycle after a load.
module mp_adder_ctl import mp_adder_pkg::*; #(
    parameter int                   NPLAYERS = DEF_NPLAYERS,
    parameter int                   DW       = DEF_DW,
    parameter int                   PWD_LEN  = DEF_PWD_LEN,
    parameter logic [PWD_LEN*4-1:0] PWD      = DEF_PWD,
    parameter int                   MAX_FAIL = DEF_MAX_FAIL
) (
    input  logic          CLK,
    input  logic          RST,
    mp_adder_ctl_if.slave bus
);

    localparam int SW = DW + $clog2(NPLAYERS);

    state_t                 state_q, state_d;
    logic [NPLAYERS*DW-1:0] pVal_q, pVal_d;
    logic [SW-1:0]          sum_q, sum_d;
    logic                   sumValid_q;
    logic                   loadPending_q;
    logic [NPLAYERS-1:0]    loadEn;
    logic [SW-1:0]          sumAll;
    logic                   grant;
    logic                   alarm;

    pwd_checker #(
        .PWD_LEN  (PWD_LEN),
        .PWD      (PWD),
        .MAX_FAIL (MAX_FAIL)
    ) u_checker (
        .clk_i    (CLK),
        .rst_i    (RST),
        .enable_i (state_q == S_WAIT),
        .digit_i  (bus.acc_data),
        .press_i  (bus.acc_bpress),
        .grant_o  (grant),
        .alarm_o  (alarm)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= S_WAIT;
            pVal_q        <= '0;
            sum_q         <= '0;
            sumValid_q    <= 1'b0;
            loadPending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pVal_q        <= pVal_d;
            sum_q         <= sum_d;
            sumValid_q    <= loadPending_q;
            loadPending_q <= |loadEn;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT: begin
                if (alarm)      state_d = S_ALARM;
                else if (grant) state_d = S_OPEN;
            end
            S_OPEN: begin
                if (bus.acc_bpress) state_d = S_WAIT;
            end
            S_ALARM: state_d = S_ALARM;
            default: state_d = S_WAIT;
        endcase
    end

    // Loads in an open cycle still land even if the same cycle relocks.
    always_comb begin
        loadEn = (state_q == S_OPEN) ? bus.p_bpress : '0;
        pVal_d = pVal_q;
        for (int i = 0; i < NPLAYERS; i++) begin
            if (loadEn[i]) pVal_d[i*DW +: DW] = bus.p_data[i*DW +: DW];
        end
    end

    always_comb begin
        sumAll = '0;
        for (int i = 0; i < NPLAYERS; i++) begin
            sumAll = sumAll + SW'(pVal_q[i*DW +: DW]);
        end
        sum_d = loadPending_q ? sumAll : sum_q;
    end

    assign bus.p_val     = pVal_q;
    assign bus.sum       = sum_q;
    assign bus.sum_valid = sumValid_q;
    assign bus.pass_g    = (state_q == S_OPEN);
    assign bus.pass_r    = (state_q == S_ALARM);
    assign bus.acc_state = state_q;

endmodule

// File: tb/tb_mp_adder_ctl.sv
// Directed bench for mp_adder_ctl: code entry, alarm, table-driven loads/sums.
module tb_mp_adder_ctl;

    logic CLK;
    logic RST;
    int   total;
    int   bad;

    mp_adder_ctl_if #(.NPLAYERS(2), .DW(4)) bus ();

    mp_adder_ctl dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] press;
        logic [3:0] ch0;
        logic [3:0] ch1;
        logic [7:0] expPVal;
        logic [4:0] expSum;
        logic       expValid;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic pressDigit(input logic [3:0] d);
        bus.acc_data   = d;
        bus.acc_bpress = 1'b1;
        tick();
        bus.acc_bpress = 1'b0;
    endtask

    task automatic enterCode(input logic [15:0] code);
        for (int k = 3; k >= 0; k--) pressDigit(code[k*4 +: 4]);
    endtask

    task automatic doReset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic applyStimulus(input int idx);
        bus.p_data   = {vecs[idx].ch1, vecs[idx].ch0};
        bus.p_bpress = vecs[idx].press;
        tick();
        bus.p_bpress = 2'b00;
        checkOutput($sformatf("vec%0d p_val", idx), 32'(bus.p_val), 32'(vecs[idx].expPVal));
        checkOutput($sformatf("vec%0d early valid", idx), 32'(bus.sum_valid), 32'd0);
        tick();
        checkOutput($sformatf("vec%0d sum", idx), 32'(bus.sum), 32'(vecs[idx].expSum));
        checkOutput($sformatf("vec%0d sum_valid", idx), 32'(bus.sum_valid), 32'(vecs[idx].expValid));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vecs[0] = '{2'b11, 4'hF, 4'hF, 8'hFF, 5'd30, 1'b1};
        vecs[1] = '{2'b01, 4'h3, 4'hA, 8'hF3, 5'd18, 1'b1};
        vecs[2] = '{2'b10, 4'h9, 4'h7, 8'h73, 5'd10, 1'b1};
        vecs[3] = '{2'b00, 4'h1, 4'h1, 8'h73, 5'd10, 1'b0};
        vecs[4] = '{2'b11, 4'h0, 4'h0, 8'h00, 5'd0,  1'b1};
        vecs[5] = '{2'b11, 4'h8, 4'h8, 8'h88, 5'd16, 1'b1};

        bus.p_data     = '0;
        bus.p_bpress   = '0;
        bus.acc_data   = '0;
        bus.acc_bpress = 1'b0;
        doReset();
        checkOutput("reset state", 32'(bus.acc_state), 32'd0);
        checkOutput("reset pass_g", 32'(bus.pass_g), 32'd0);
        checkOutput("reset pass_r", 32'(bus.pass_r), 32'd0);
        checkOutput("reset p_val", 32'(bus.p_val), 32'd0);
        checkOutput("reset sum", 32'(bus.sum), 32'd0);
        checkOutput("reset sum_valid", 32'(bus.sum_valid), 32'd0);

        // Correct code opens on the cycle after the fourth press
        pressDigit(4'h3);
        pressDigit(4'h1);
        pressDigit(4'h5);
        checkOutput("three digits state", 32'(bus.acc_state), 32'd0);
        pressDigit(4'h3);
        checkOutput("open state", 32'(bus.acc_state), 32'd1);
        checkOutput("open pass_g", 32'(bus.pass_g), 32'd1);

        for (int i = 0; i < 6; i++) applyStimulus(i);

        // Simultaneous load and relock
        bus.p_data     = {4'h5, 4'h2};
        bus.p_bpress   = 2'b11;
        bus.acc_bpress = 1'b1;
        tick();
        bus.p_bpress   = 2'b00;
        bus.acc_bpress = 1'b0;
        checkOutput("load+relock p_val", 32'(bus.p_val), 32'h52);
        checkOutput("load+relock state", 32'(bus.acc_state), 32'd0);
        tick();
        checkOutput("load+relock sum", 32'(bus.sum), 32'd7);
        checkOutput("load+relock valid", 32'(bus.sum_valid), 32'd1);

        // Loads ignored while locked
        bus.p_data   = 8'h00;
        bus.p_bpress = 2'b11;
        tick();
        bus.p_bpress = 2'b00;
        tick();
        checkOutput("locked p_val", 32'(bus.p_val), 32'h52);
        checkOutput("locked sum_valid", 32'(bus.sum_valid), 32'd0);

        // Plain relock keeps p_val
        enterCode(16'h3153);
        checkOutput("reopen state", 32'(bus.acc_state), 32'd1);
        pressDigit(4'h0);
        checkOutput("relock state", 32'(bus.acc_state), 32'd0);
        checkOutput("relock p_val", 32'(bus.p_val), 32'h52);

        // Mismatch on first digit only must still fail the attempt
        enterCode(16'h4153);
        checkOutput("bad first digit", 32'(bus.acc_state), 32'd0);

        // Reset mid-entry clears the digit index
        doReset();
        pressDigit(4'h3);
        pressDigit(4'h1);
        doReset();
        enterCode(16'h3153);
        checkOutput("reset mid-entry open", 32'(bus.acc_state), 32'd1);

        // Success clears the fail count
        doReset();
        enterCode(16'h3154);
        enterCode(16'h3154);
        enterCode(16'h3153);
        checkOutput("success after 2 fails", 32'(bus.acc_state), 32'd1);
        pressDigit(4'h0);
        enterCode(16'h3154);
        enterCode(16'h3154);
        checkOutput("fail count cleared", 32'(bus.acc_state), 32'd0);
        enterCode(16'h3154);
        checkOutput("alarm after 3 new fails", 32'(bus.acc_state), 32'd2);

        // Three bad attempts -> alarm, then everything ignored
        doReset();
        enterCode(16'h3154);
        enterCode(16'h3154);
        checkOutput("two fails no alarm", 32'(bus.pass_r), 32'd0);
        enterCode(16'h3154);
        checkOutput("alarm pass_r", 32'(bus.pass_r), 32'd1);
        checkOutput("alarm state", 32'(bus.acc_state), 32'd2);
        enterCode(16'h3153);
        bus.p_data   = 8'hFF;
        bus.p_bpress = 2'b11;
        tick();
        bus.p_bpress = 2'b00;
        checkOutput("alarm p_val", 32'(bus.p_val), 32'd0);
        checkOutput("alarm sticky", 32'(bus.acc_state), 32'd2);
        checkOutput("alarm pass_g", 32'(bus.pass_g), 32'd0);

        // Reset beats a digit press in the alarm state
        RST            = 1'b1;
        bus.acc_bpress = 1'b1;
        tick();
        bus.acc_bpress = 1'b0;
        RST            = 1'b0;
        checkOutput("alarm reset state", 32'(bus.acc_state), 32'd0);
        checkOutput("alarm reset pass_r", 32'(bus.pass_r), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mp_adder_ctl.md
MP_ADDER_CTL -- requirements
Module: mp_adder_ctl

Interface
REQ-001 Parameter NPLAYERS, default 2, number of player channels (2..8).
REQ-002 Parameter DW, default 4, width of each player value.
REQ-003 Parameter PWD_LEN, default 4, number of 4-bit access-code digits.
REQ-004 Parameter PWD, default 16'h3153, access code; most-significant digit is entered first.
REQ-005 Parameter MAX_FAIL, default 3, failed code attempts before alarm.
REQ-006 CLK  in  1  sole clock; all state updates on its rising edge.
REQ-007 RST  in  1  synchronous, active-high reset.
REQ-008 p_data  in  NPLAYERS*DW  player values; channel i at bits [i*DW +: DW].
REQ-009 p_bpress  in  NPLAYERS  single-cycle load pulses, one per channel.
REQ-010 acc_data  in  4  access-code digit.
REQ-011 acc_bpress  in  1  single-cycle digit-enter / relock pulse.
REQ-012 p_val  out  NPLAYERS*DW  registered player values.
REQ-013 sum  out  DW+$clog2(NPLAYERS)  registered sum of all p_val channels.
REQ-014 sum_valid  out  1  one-cycle pulse when sum updates.
REQ-015 pass_g, pass_r  out  1 each  access granted / alarm indicators.
REQ-016 acc_state  out  3  current FSM state encoding.

Function
REQ-017 FSM states: S_WAIT (code entry), S_OPEN (loads permitted), S_ALARM (terminal until RST).
REQ-018 In S_WAIT, each acc_bpress captures acc_data as the next digit and advances digit index 0..PWD_LEN-1.
REQ-019 A per-attempt mismatch flag SHALL be set if any entered digit differs from the corresponding PWD digit.
REQ-020 On the PWD_LEN-th digit: no mismatch -> S_OPEN, fail count cleared; mismatch -> fail count +1, index and flag cleared.
REQ-021 When fail count reaches MAX_FAIL, next state SHALL be S_ALARM; all inputs ignored there until RST.
REQ-022 In S_OPEN, acc_bpress SHALL relock: next state S_WAIT, index 0, p_val retained.
REQ-023 In S_OPEN, p_bpress[i] loads p_data channel i into p_val channel i on that edge; several simultaneous pulses load all asserted channels in the same cycle.
REQ-024 p_bpress SHALL be ignored outside S_OPEN.
REQ-025 sum SHALL equal the full-width, non-wrapping sum of p_val channels, registered one cycle after any load; sum_valid pulses in that same cycle.
REQ-026 p_bpress and acc_bpress in the same S_OPEN cycle: loads take effect, then relock.
REQ-027 pass_g=1 exactly in S_OPEN; pass_r=1 exactly in S_ALARM.

Reset
REQ-028 RST SHALL set state S_WAIT, digit index 0, mismatch flag 0, fail count 0, p_val 0, sum 0, sum_valid 0, pass_g 0, pass_r 0.
REQ-029 RST asserted mid-entry or in S_ALARM SHALL take priority over every other input in that cycle.

Structure
REQ-030 State encodings (S_WAIT=0, S_OPEN=1, S_ALARM=2) and parameter defaults SHALL live in a shared package, mp_adder_pkg.
REQ-031 Code-entry logic (index, mismatch, fail count) SHALL be one sub-module, pwd_checker, exposing grant and alarm pulses.

Verification
REQ-032 Digits 3,1,5,3 with one acc_bpress each -> pass_g=1 the cycle after the fourth press, acc_state=1.
REQ-033 Three attempts of 3,1,5,4 -> pass_r=1 after the 12th press; later 3,1,5,3 and p_bpress leave p_val=0.
REQ-034 Open; p_data ch0=4'hF, ch1=4'hF, p_bpress=2'b11 one cycle -> next cycle p_val=8'hFF, then sum=5'd30 with sum_valid pulse.
REQ-035 Open; acc_bpress -> S_WAIT with p_val held; p_bpress ignored until the code is re-entered.
REQ-036 RST after two correct digits, then 3,1,5,3 -> S_OPEN (index cleared by reset).
